// File: rtl/ddio_pkg.sv
// Shared definitions for the DDR input capture block.
package ddio_pkg;

    localparam int unsigned DDIO_DEFAULT_WIDTH = 8;

    typedef logic [DDIO_DEFAULT_WIDTH-1:0] ddio_lane_t;

endpackage : ddio_pkg

// File: rtl/ddio_in_bit.sv
// One lane of DDR input capture: rising and falling samples re-aligned to the rising edge.
// Optional output register stage enabled by defining DDIO_IN_OUTREG_EN.
module ddio_in_bit
    import ddio_pkg::*;
(
    input  logic inclock,
    input  logic aclr_n,
    input  logic datain,
    output logic dataout_h,
    output logic dataout_l
);

    logic rise_q;
    logic fall_q;
    logic fall_rq;

    // Rising-edge sample, and the falling sample moved into the rising domain so it
    // pairs with the rise that follows it (the earlier bit ends up on the low output).
    always_ff @(posedge inclock or negedge aclr_n) begin
        if (!aclr_n) begin
            rise_q  <= 1'b0;
            fall_rq <= 1'b0;
        end else begin
            rise_q  <= datain;
            fall_rq <= fall_q;
        end
    end

    always_ff @(negedge inclock or negedge aclr_n) begin
        if (!aclr_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= datain;
        end
    end

`ifdef DDIO_IN_OUTREG_EN
    logic out_h_q;
    logic out_l_q;

    always_ff @(posedge inclock or negedge aclr_n) begin
        if (!aclr_n) begin
            out_h_q <= 1'b0;
            out_l_q <= 1'b0;
        end else begin
            out_h_q <= rise_q;
            out_l_q <= fall_rq;
        end
    end

    assign dataout_h = out_h_q;
    assign dataout_l = out_l_q;
`else
    assign dataout_h = rise_q;
    assign dataout_l = fall_rq;
`endif

endmodule : ddio_in_bit

// File: rtl/ddio_in.sv
// Parallel DDR input capture for WIDTH independent lanes, outputs aligned to the rising edge.
// Define DDIO_IN_OUTREG_EN to add one output register cycle on both buses.
module ddio_in
    import ddio_pkg::*;
#(
    parameter int unsigned WIDTH = DDIO_DEFAULT_WIDTH
) (
    input  logic             inclock,
    input  logic             aclr_n,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout_h,
    output logic [WIDTH-1:0] dataout_l
);

    for (genvar lane = 0; lane < WIDTH; lane++) begin : g_lane
        ddio_in_bit u_bit (
            .inclock   (inclock),
            .aclr_n    (aclr_n),
            .datain    (datain[lane]),
            .dataout_h (dataout_h[lane]),
            .dataout_l (dataout_l[lane])
        );
    end

endmodule : ddio_in

// File: tb/tb_ddio_in.sv
// Self-checking bench for ddio_in: scoreboard of expected (low, high) pairs per rising edge.
// Honours DDIO_IN_OUTREG_EN by delaying the expected pairs one rising edge.
module tb_ddio_in;
    import ddio_pkg::*;

`ifdef DDIO_IN_OUTREG_EN
    localparam int OUT_LAT = 1;
`else
    localparam int OUT_LAT = 0;
`endif

    typedef struct packed {
        ddio_lane_t l;
        ddio_lane_t h;
    } pair_t;

    logic       inclock;
    logic       aclr_n;
    ddio_lane_t datain;
    ddio_lane_t dataout_h;
    ddio_lane_t dataout_l;

    pair_t      sb[$];
    ddio_lane_t modelFall;
    int         numChecks;
    int         numFailures;

    ddio_in #(.WIDTH(DDIO_DEFAULT_WIDTH)) dut (
        .inclock   (inclock),
        .aclr_n    (aclr_n),
        .datain    (datain),
        .dataout_h (dataout_h),
        .dataout_l (dataout_l)
    );

    initial inclock = 1'b0;
    always #5 inclock = ~inclock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input ddio_lane_t actual, input ddio_lane_t expected);
        numChecks++;
        if (actual !== expected) begin
            numFailures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reset clears every stage, so the model forgets the last fall and the
    // output register (if present) starts out holding a zero pair.
    task automatic resetModel();
        sb.delete();
        modelFall = '0;
        for (int i = 0; i < OUT_LAT; i++) sb.push_back('{l: '0, h: '0});
    endtask

    task automatic riseStep(input ddio_lane_t riseVal, input string tag);
        pair_t p;
        sb.push_back('{l: modelFall, h: riseVal});
        @(posedge inclock);
        #1;
        if (sb.size() > OUT_LAT) begin
            p = sb.pop_front();
            checkOutput({tag, "_l"}, dataout_l, p.l);
            checkOutput({tag, "_h"}, dataout_h, p.h);
        end
    endtask

    // Called in the high phase: present fallVal to the falling edge, then riseVal to the next rise.
    task automatic applyStimulus(input ddio_lane_t fallVal, input ddio_lane_t riseVal, input string tag);
        datain = fallVal;
        @(negedge inclock);
        modelFall = fallVal;
        #1;
        datain = riseVal;
        riseStep(riseVal, tag);
    endtask

    initial begin
        numChecks   = 0;
        numFailures = 0;
        aclr_n      = 1'b0;
        datain      = '0;
        resetModel();
        #2;
        checkOutput("reset_h", dataout_h, 8'h00);
        checkOutput("reset_l", dataout_l, 8'h00);

        // Release after a falling edge seen in reset: first rise gives h only.
        @(negedge inclock);
        #1;
        aclr_n = 1'b1;
        datain = 8'hFF;
        riseStep(8'hFF, "post_reset_rise1");
        applyStimulus(8'hFF, 8'hFF, "post_reset_rise2");

        applyStimulus(8'hA5, 8'h3C, "pairing");
        applyStimulus(8'h08, 8'h00, "lane3_a");
        applyStimulus(8'h08, 8'h00, "lane3_b");
        applyStimulus(8'h00, 8'hFF, "alt_a");
        applyStimulus(8'hFF, 8'h00, "alt_b");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(ddio_lane_t'($urandom_range(0, 255)),
                          ddio_lane_t'($urandom_range(0, 255)), "random");
        end

        for (int i = 0; i <= OUT_LAT; i++) applyStimulus(8'h5A, 8'h5A, "pre_midreset");

        // Now in the high phase with both outputs at 8'h5A.
        #1;
        aclr_n = 1'b0;
        #1;
        checkOutput("midreset_h", dataout_h, 8'h00);
        checkOutput("midreset_l", dataout_l, 8'h00);
        resetModel();

        @(negedge inclock);
        #1;
        checkOutput("midreset_hold_h", dataout_h, 8'h00);
        checkOutput("midreset_hold_l", dataout_l, 8'h00);
        aclr_n = 1'b1;
        datain = 8'hC3;
        riseStep(8'hC3, "resume_rise1");
        applyStimulus(8'hA5, 8'h3C, "resume_pairing");
        applyStimulus(8'h81, 8'h7E, "resume_b");
        applyStimulus(8'h00, 8'h00, "drain");

        checkOutput("sb_depth", ddio_lane_t'(sb.size()), ddio_lane_t'(OUT_LAT));

        $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
        $finish;
    end

endmodule : tb_ddio_in
